// File: rtl/phase_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// phase_accumulator_pkg
// Shared definitions for the DDS phase accumulator slice:
//   - PHASE_W        accumulator width (32)
//   - state_t        handshake FSM encodings (IDLE / RUN / STALL)
//   - LFSR_SEED      dither LFSR reset value
//   - LFSR_TAPS      Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - lfsr_next()    one Galois LFSR advance
// ---------------------------------------------------------------------------
package phase_accumulator_pkg;

   localparam int PHASE_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STALL = 2'b10
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Galois form: bits 15,13,12,10 map to x^16,x^14,x^13,x^11.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      logic [15:0] fb;
      fb = cur[0] ? LFSR_TAPS : 16'h0000;
      return {1'b0, cur[15:1]} ^ fb;
   endfunction

endpackage

// File: rtl/cla_32.sv
// ---------------------------------------------------------------------------
// cla_32
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Ports:
//   i_a, i_b  in  32  addends
//   i_c       in  1   carry in
//   o_s       out 32  sum (mod 2^32)
//   o_c       out 1   carry out of bit 31
// ---------------------------------------------------------------------------
module cla_32 (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_c,
   output logic [31:0] o_s,
   output logic        o_c
);

   logic [31:0] g_s;
   logic [31:0] p_s;
   logic [31:0] c_s;
   logic        co_s;

   assign g_s = i_a & i_b;
   assign p_s = i_a ^ i_b;

   // Carry generation: full lookahead inside each nibble, group G/P between nibbles.
   always_comb begin
      logic       carry_v;
      logic [3:0] g_v;
      logic [3:0] p_v;
      c_s     = 32'h0000_0000;
      carry_v = i_c;
      g_v     = 4'h0;
      p_v     = 4'h0;
      for (int k = 0; k < 8; k++) begin
         g_v = g_s[4*k +: 4];
         p_v = p_s[4*k +: 4];
         c_s[4*k]   = carry_v;
         c_s[4*k+1] = g_v[0] | (p_v[0] & carry_v);
         c_s[4*k+2] = g_v[1] | (p_v[1] & g_v[0]) | (p_v[1] & p_v[0] & carry_v);
         c_s[4*k+3] = g_v[2] | (p_v[2] & g_v[1]) | (p_v[2] & p_v[1] & g_v[0])
                    | (p_v[2] & p_v[1] & p_v[0] & carry_v);
         carry_v    = g_v[3] | (p_v[3] & g_v[2]) | (p_v[3] & p_v[2] & g_v[1])
                    | (p_v[3] & p_v[2] & p_v[1] & g_v[0]) | ((&p_v) & carry_v);
      end
      co_s = carry_v;
   end

   assign o_s = p_s ^ c_s;
   assign o_c = co_s;

endmodule

// File: rtl/phase_accumulator_lfsr.sv
// ---------------------------------------------------------------------------
// phase_lfsr
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) used as phase dither source.
// Ports:
//   i_clk    in  1   clock, rising edge
//   i_rst    in  1   asynchronous active-high reset (loads LFSR_SEED)
//   i_adv    in  1   advance one step this cycle
//   o_state  out 16  current LFSR contents
// ---------------------------------------------------------------------------
module phase_lfsr
   import phase_accumulator_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_adv,
   output logic [15:0] o_state
);

   logic [15:0] state_r;

   // LFSR register: moves only when the accumulator steps.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= LFSR_SEED;
      end else if (i_adv) begin
         state_r <= lfsr_next(state_r);
      end else begin
         state_r <= state_r;
      end
   end

   assign o_state = state_r;

endmodule

// File: rtl/phase_accumulator.sv
// ---------------------------------------------------------------------------
// phase_accumulator
// DDS phase accumulator feeding the sin/cos stage. A 32-bit accumulator adds
// the active tuning word each step (via cla_32); the pre-add phase, truncated
// to OUT_W bits, leaves through a valid/ready handshake. Tuning words are
// double-buffered (pending -> active) so the phase never jumps.
// Optional build macro: PHASE_DITHER_EN adds LFSR dither ahead of truncation.
// Parameters:
//   OUT_W        output phase width, 8..16 (default 12)
// Ports:
//   i_clk        in   1      clock, rising edge
//   i_rst        in   1      asynchronous active-high reset
//   i_en         in   1      run enable
//   i_sync       in   1      phase reset: clear accumulator, flush output
//   i_ftw        in   32     new tuning word
//   i_ftw_valid  in   1      tuning word offer
//   o_ftw_ready  out  1      pending buffer empty
//   o_phase      out  OUT_W  phase sample
//   o_wrap       out  1      this sample's step overflowed 2^32
//   o_valid      out  1      o_phase/o_wrap valid
//   i_ready      in   1      downstream accepts sample
// ---------------------------------------------------------------------------
module phase_accumulator
   import phase_accumulator_pkg::*;
#(
   parameter int OUT_W = 12
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic [31:0]      i_ftw,
   input  logic             i_ftw_valid,
   output logic             o_ftw_ready,
   output logic [OUT_W-1:0] o_phase,
   output logic             o_wrap,
   output logic             o_valid,
   input  logic             i_ready
);

   logic [PHASE_W-1:0] acc_r;
   logic [PHASE_W-1:0] ftw_act_r;
   logic [PHASE_W-1:0] ftw_pend_r;
   logic               ftw_ready_r;   // high = pending buffer empty
   logic [OUT_W-1:0]   phase_r;
   logic               wrap_r;
   logic               valid_r;
   state_t             state_r;
   state_t             state_nx_s;

   logic               step_s;
   logic               ftw_take_s;
   logic [PHASE_W-1:0] acc_sum_s;
   logic               acc_co_s;
   logic [PHASE_W-1:0] phase_src_s;

   assign step_s     = i_en && (!valid_r || i_ready) && !i_sync;
   assign ftw_take_s = i_ftw_valid && ftw_ready_r;

   cla_32 u_acc_add (
      .i_a (acc_r),
      .i_b (ftw_act_r),
      .i_c (1'b0),
      .o_s (acc_sum_s),
      .o_c (acc_co_s)
   );

`ifdef PHASE_DITHER_EN
   logic [15:0]        lfsr_s;
   logic [PHASE_W-1:0] dith_add_s;
   logic [PHASE_W-1:0] dith_sum_s;
   logic               dith_co_s;
   logic               dith_unused_s;

   phase_lfsr u_lfsr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_adv   (step_s),
      .o_state (lfsr_s)
   );

   // Dither spans just below the output LSB so it only ever rounds by one code.
   assign dith_add_s = PHASE_W'(lfsr_s) << (16 - OUT_W);

   cla_32 u_dith_add (
      .i_a (acc_r),
      .i_b (dith_add_s),
      .i_c (1'b0),
      .o_s (dith_sum_s),
      .o_c (dith_co_s)
   );

   // Truncated bits and the dither carry are deliberately discarded.
   assign dith_unused_s = ^{dith_co_s, dith_sum_s[PHASE_W-OUT_W-1:0]};
   assign phase_src_s   = dith_sum_s;
`else
   assign phase_src_s = acc_r;
`endif

   // Handshake FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Handshake FSM next state; sync overrides everything.
   always_comb begin
      state_nx_s = state_r;
      if (i_sync) begin
         state_nx_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (step_s) state_nx_s = ST_RUN;
               else        state_nx_s = ST_IDLE;
            end
            ST_RUN, ST_STALL: begin
               if (!i_ready)  state_nx_s = ST_STALL;
               else if (i_en) state_nx_s = ST_RUN;
               else           state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
         endcase
      end
   end

   // Accumulator, output sample and tuning-word double buffer.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc_r       <= 32'h0000_0000;
         ftw_act_r   <= 32'h0000_0000;
         ftw_pend_r  <= 32'h0000_0000;
         ftw_ready_r <= 1'b1;
         phase_r     <= {OUT_W{1'b0}};
         wrap_r      <= 1'b0;
         valid_r     <= 1'b0;
      end else begin
         valid_r <= (state_nx_s != ST_IDLE);
         if (i_sync) begin
            acc_r   <= 32'h0000_0000;
            phase_r <= {OUT_W{1'b0}};
            wrap_r  <= 1'b0;
            if (!ftw_ready_r) begin
               ftw_act_r   <= ftw_pend_r;
               ftw_ready_r <= 1'b1;
            end else if (i_ftw_valid) begin
               ftw_pend_r  <= i_ftw;
               ftw_ready_r <= 1'b0;
            end else begin
               ftw_ready_r <= ftw_ready_r;
            end
         end else begin
            if (step_s) begin
               phase_r <= phase_src_s[PHASE_W-1 -: OUT_W];
               acc_r   <= acc_sum_s;
               wrap_r  <= acc_co_s;
            end else begin
               phase_r <= phase_r;
            end
            // The step still used the old word; the pending one takes over after it.
            if (step_s && !ftw_ready_r) begin
               ftw_act_r   <= ftw_pend_r;
               ftw_ready_r <= 1'b1;
            end else if (ftw_take_s) begin
               ftw_pend_r  <= i_ftw;
               ftw_ready_r <= 1'b0;
            end else begin
               ftw_ready_r <= ftw_ready_r;
            end
         end
      end
   end

   assign o_ftw_ready = ftw_ready_r;
   assign o_phase     = phase_r;
   assign o_wrap      = wrap_r;
   assign o_valid     = valid_r;

endmodule
